// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, inst}, optional bypass via FETCH_BUFFER_BYPASS_EN.
// Latency: rdata returned in cycle N appears on out_* in cycle N+1 (same cycle when bypass is taken).
// Backpressure: req_ready drops once stored plus in-flight entries reach DEPTH; flush clears everything.
module inst_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    logic [CNT_W:0]    occ;
    logic              req_fire;
    logic              stored_vld;
    logic              push;
    logic              pop;

    // Occupancy counts the in-flight read so the queue can never overflow.
    assign occ        = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
    assign req_ready  = rst && !flush && (occ < DEPTH_OCC);
    assign req_fire   = req_valid && req_ready;
    assign stored_vld = (cnt != '0);
    assign pop        = stored_vld && out_ready && !flush;
    assign count      = cnt;

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass;

    // Empty queue: hand the returning instruction straight to decode.
    assign bypass    = !stored_vld && pend && !flush;
    assign push      = rst && pend && !flush && !(bypass && out_ready);
    assign out_valid = stored_vld || bypass;
    assign out_pc    = bypass ? pend_pc : (stored_vld ? mem_pc[rd_ptr]   : '0);
    assign out_inst  = bypass ? rdata   : (stored_vld ? mem_inst[rd_ptr] : '0);
`else
    assign push      = rst && pend && !flush;
    assign out_valid = stored_vld;
    assign out_pc    = stored_vld ? mem_pc[rd_ptr]   : '0;
    assign out_inst  = stored_vld ? mem_inst[rd_ptr] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (flush) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pend    <= 1'b0;
        end else begin
            pend <= req_fire;
            if (req_fire) begin
                pend_pc <= req_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pend_pc;
            mem_inst[wr_ptr] <= rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (cnt == DEPTH_CNT)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed-vector bench for inst_fetch_buffer (DEPTH=4); inputs change 1ns after posedge, outputs sampled mid-cycle.
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic [31:0] rdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic dead_seen = 1'b0;

`ifdef FETCH_BUFFER_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    inst_fetch_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .rdata     (rdata),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs just after posedge, then settle to mid-cycle for sampling.
    task automatic tick(input logic rs, input logic rv, input logic [31:0] pc,
                        input logic [31:0] rd, input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        rst       = rs;
        req_valid = rv;
        req_pc    = pc;
        rdata     = rd;
        flush     = fl;
        out_ready = ordy;
        #4;
        if (out_valid && out_inst == 32'h0000_DEAD) dead_seen = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_vld"},  out_valid, 1'b1);
        check({tag, "_pc"},   out_pc,    pc);
        check({tag, "_inst"}, out_inst,  inst);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_pc = '0; rdata = '0; flush = 1'b0; out_ready = 1'b0;

        // 1: reset, then stream three instructions
        tick(0, 0, 32'h0, 32'h0, 0, 0);
        check("rst_rdy", req_ready, 1'b0);
        tick(0, 0, 32'h0, 32'h0, 0, 0);
        check("rst_rdy2", req_ready, 1'b0);
        check("rst_cnt",  count,     3'd0);
        check("rst_vld",  out_valid, 1'b0);
        check("rst_pc",   out_pc,    32'h0);
        check("rst_inst", out_inst,  32'h0);

        tick(1, 1, 32'hBFC0_0000, 32'h0, 0, 1);
        check("s1_rdy", req_ready, 1'b1);
        check("s1_vld", out_valid, 1'b0);
        tick(1, 1, 32'hBFC0_0004, 32'h11, 0, 1);
        if (BYP) check_head("s2_byp", 32'hBFC0_0000, 32'h11);
        else     check("s2_vld", out_valid, 1'b0);
        tick(1, 1, 32'hBFC0_0008, 32'h22, 0, 1);
        if (BYP) check_head("s3_byp", 32'hBFC0_0004, 32'h22);
        else     check_head("s3",     32'hBFC0_0000, 32'h11);
        tick(1, 0, 32'h0, 32'h33, 0, 1);
        if (BYP) check_head("s4_byp", 32'hBFC0_0008, 32'h33);
        else     check_head("s4",     32'hBFC0_0004, 32'h22);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        if (BYP) check("s5_vld", out_valid, 1'b0);
        else     check_head("s5", 32'hBFC0_0008, 32'h33);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("s6_vld", out_valid, 1'b0);
        check("s6_cnt", count,     3'd0);

        // 2: stall fill, exactly four requests accepted, then drain in order
        tick(1, 1, 32'h1000, 32'h0,  0, 0);
        check("f1_rdy", req_ready, 1'b1);
        tick(1, 1, 32'h1004, 32'hA0, 0, 0);
        check("f2_rdy", req_ready, 1'b1);
        tick(1, 1, 32'h1008, 32'hA1, 0, 0);
        check("f3_rdy", req_ready, 1'b1);
        tick(1, 1, 32'h100C, 32'hA2, 0, 0);
        check("f4_rdy", req_ready, 1'b1);
        check("f4_cnt", count,     3'd2);
        tick(1, 1, 32'h1010, 32'hA3, 0, 0);
        check("f5_rdy", req_ready, 1'b0);
        check("f5_cnt", count,     3'd3);
        tick(1, 1, 32'h1010, 32'hBAD, 0, 0);
        check("f6_rdy", req_ready, 1'b0);
        check("f6_cnt", count,     3'd4);
        check_head("f6", 32'h1000, 32'hA0);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("d1_rdy", req_ready, 1'b0);
        check_head("d1", 32'h1000, 32'hA0);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("d2_rdy", req_ready, 1'b1);
        check("d2_cnt", count,     3'd3);
        check_head("d2", 32'h1004, 32'hA1);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check_head("d3", 32'h1008, 32'hA2);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check_head("d4", 32'h100C, 32'hA3);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("d5_vld", out_valid, 1'b0);
        check("d5_cnt", count,     3'd0);

        // 3: simultaneous push and pop, write pointer wraps 3 -> 0 -> 1
        tick(1, 1, 32'h2000, 32'h0,  0, 0);
        tick(1, 1, 32'h2004, 32'hB0, 0, 0);
        tick(1, 1, 32'h2008, 32'hB1, 0, 0);
        tick(1, 0, 32'h0,    32'hB2, 0, 1);
        check("t4_cnt", count, 3'd2);
        check_head("t4", 32'h2000, 32'hB0);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("t5_cnt", count, 3'd2);
        check_head("t5", 32'h2004, 32'hB1);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("t6_cnt", count, 3'd1);
        check_head("t6", 32'h2008, 32'hB2);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("t7_vld", out_valid, 1'b0);

        // 4: flush with three stored entries and one in flight
        tick(1, 1, 32'h3000, 32'h0,  0, 0);
        tick(1, 1, 32'h3004, 32'hC0, 0, 0);
        tick(1, 1, 32'h3008, 32'hC1, 0, 0);
        tick(1, 1, 32'h300C, 32'hC2, 0, 0);
        check("u4_rdy", req_ready, 1'b1);
        tick(1, 1, 32'h3010, 32'h0000_DEAD, 1, 1);
        check("u5_rdy", req_ready, 1'b0);
        check("u5_cnt", count,     3'd3);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("u6_cnt", count,     3'd0);
        check("u6_vld", out_valid, 1'b0);
        tick(1, 1, 32'h0000_0100, 32'h0, 0, 1);
        check("u7_rdy", req_ready, 1'b1);
        tick(1, 0, 32'h0, 32'h77, 0, 0);
        tick(1, 0, 32'h0, 32'h0,  0, 1);
        check_head("u9", 32'h0000_0100, 32'h77);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("u10_vld", out_valid, 1'b0);
        check("no_dead", dead_seen, 1'b0);

        // 5: reset mid-stream
        tick(1, 1, 32'h4000, 32'h0,  0, 0);
        tick(1, 1, 32'h4004, 32'hD0, 0, 0);
        tick(1, 1, 32'h4008, 32'hD1, 0, 0);
        tick(0, 1, 32'h400C, 32'hD2, 0, 0);
        check("v4_rdy", req_ready, 1'b0);
        check("v4_cnt", count,     3'd2);
        tick(1, 0, 32'h0, 32'h0, 0, 0);
        check("v5_cnt", count,     3'd0);
        check("v5_vld", out_valid, 1'b0);
        check("v5_rdy", req_ready, 1'b1);
        tick(1, 0, 32'h0, 32'h0, 0, 0);
        check("v6_cnt", count,     3'd0);
        check("v6_vld", out_valid, 1'b0);

        // 6: bypass timing with out_ready high, then low
        tick(1, 1, 32'h40, 32'h0, 0, 1);
        tick(1, 0, 32'h0,  32'hC, 0, 1);
        check("w2_vld", out_valid, BYP);
        if (BYP) check_head("w2_byp", 32'h40, 32'hC);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("w3_cnt", count, BYP ? 3'd0 : 3'd1);
        if (BYP) check("w3_vld", out_valid, 1'b0);
        else     check_head("w3", 32'h40, 32'hC);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("w4_vld", out_valid, 1'b0);
        check("w4_cnt", count,     3'd0);

        tick(1, 1, 32'h44, 32'h0, 0, 0);
        tick(1, 0, 32'h0,  32'hD, 0, 0);
        check("x2_vld", out_valid, BYP);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("x3_cnt", count, 3'd1);
        check_head("x3", 32'h44, 32'hD);
        tick(1, 0, 32'h0, 32'h0, 0, 1);
        check("x4_vld", out_valid, 1'b0);
        check("x4_cnt", count,     3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
